// File: rtl/meta_count_reader.sv
// meta_count_reader: reader side of the metastability detector's Counts/ready/re
// handshake. Collects 2**LOG2_SAMPLES count words, reduces them to sum/min/max/mean,
// and presents one record on a valid/ack handshake. A watchdog aborts a run when
// the detector stalls, either never raising ready or never dropping it.
//
// Handshakes:
//   detector side: det_ready=1 means a word is pending on det_counts; the reader
//     answers with a one-cycle det_re pulse (CAPTURE), then waits for det_ready=0
//     before it looks for the next word.
//   result side: res_valid rises in DONE and holds, with res_* stable, until a
//     cycle with res_ack=1; res_valid falls the next cycle. res_* then hold
//     until the next start.
module meta_count_reader #(
    parameter int LOG2_SAMPLES = 4,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CNT_W-1:0]              det_counts,
    input  logic                          det_ready,
    output logic                          det_re,
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ack,
    output logic [CNT_W+LOG2_SAMPLES-1:0] res_sum,
    output logic [CNT_W-1:0]              res_min,
    output logic [CNT_W-1:0]              res_max,
    output logic [CNT_W-1:0]              res_mean,
    output logic [LOG2_SAMPLES:0]         res_n,
    output logic                          res_timeout,
    output logic [2:0]                    dbg_state
);

    localparam int SUM_W = CNT_W + LOG2_SAMPLES;
    localparam int N_W   = LOG2_SAMPLES + 1;
    // Watchdog only has to count up to TIMEOUT-1.
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_CAPTURE  = 3'd2,
        S_RELEASE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_clear;
    logic              w_capture;
    logic              w_wd_clr;
    logic              w_wd_inc;
    logic              w_abort;
    logic [WD_W-1:0]   r_wd;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_min;
    logic [CNT_W-1:0]  r_max;
    logic [N_W-1:0]    r_n;
    logic              r_timeout;
    logic              r_det_re;
    logic              r_busy;
    logic              r_valid;

    // State register; flags are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_det_re <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_det_re <= (w_next_state == S_CAPTURE);
            r_busy   <= (w_next_state != S_IDLE);
            r_valid  <= (w_next_state == S_DONE);
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_next_state = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (det_ready) begin
                    w_wd_clr     = 1'b1;
                    w_next_state = S_CAPTURE;
                end else if (r_wd == WD_LAST) begin
                    w_wd_clr     = 1'b1;
                    w_abort      = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_wd_inc     = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = S_RELEASE;
            end
            S_RELEASE: begin
                if (!det_ready) begin
                    w_wd_clr     = 1'b1;
                    // r_n never exceeds 2**LOG2_SAMPLES, so its MSB alone marks a full run.
                    w_next_state = r_n[LOG2_SAMPLES] ? S_DONE : S_WAIT_RDY;
                end else if (r_wd == WD_LAST) begin
                    w_wd_clr     = 1'b1;
                    w_abort      = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_wd_inc     = 1'b1;
                end
            end
            S_DONE: begin
                if (res_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Accumulators, watchdog and abort flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum     <= '0;
            r_min     <= '1;
            r_max     <= '0;
            r_n       <= '0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
        end else begin
            if (w_clear) begin
                r_sum     <= '0;
                r_min     <= '1;
                r_max     <= '0;
                r_n       <= '0;
                r_timeout <= 1'b0;
            end
            if (w_capture) begin
                r_sum <= r_sum + SUM_W'(det_counts);
                r_n   <= r_n + N_W'(1);
                if (det_counts < r_min) begin
                    r_min <= det_counts;
                end
                if (det_counts > r_max) begin
                    r_max <= det_counts;
                end
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if (w_clear || w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

    assign det_re      = r_det_re;
    assign busy        = r_busy;
    assign res_valid   = r_valid;
    assign res_sum     = r_sum;
    assign res_min     = r_min;
    assign res_max     = r_max;
    assign res_mean    = CNT_W'(r_sum >> LOG2_SAMPLES);
    assign res_n       = r_n;
    assign res_timeout = r_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_meta_count_reader.sv
// Bench for meta_count_reader: a behavioural detector serves queued words with
// random gaps, and each run's record is compared with statistics computed directly
// from the list of words the run should have consumed.
module tb_meta_count_reader;

    localparam int L      = 2;
    localparam int CW     = 16;
    localparam int TO     = 50;
    localparam int N      = 1 << L;
    localparam int SW     = CW + L;
    localparam int BUDGET = 2000;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] det_counts;
    logic          det_ready;
    logic          det_re;
    logic          busy;
    logic          res_valid;
    logic          res_ack;
    logic [SW-1:0] res_sum;
    logic [CW-1:0] res_min;
    logic [CW-1:0] res_max;
    logic [CW-1:0] res_mean;
    logic [L:0]    res_n;
    logic          res_timeout;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] src_q[$];
    logic [CW-1:0] words[$];
    int            det_mode  = M_NORMAL;
    int            flush_req = 0;
    int            re_cnt    = 0;
    int            re_base   = 0;

    meta_count_reader #(
        .LOG2_SAMPLES(L),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .det_counts (det_counts),
        .det_ready  (det_ready),
        .det_re     (det_re),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_mean   (res_mean),
        .res_n      (res_n),
        .res_timeout(res_timeout),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural detector: acts on the falling edge. Presents a word with ready,
    // drops ready one cycle after it sees re, then waits a random gap.
    initial begin
        bit pend;
        int gap;
        int flush_ack;
        pend       = 1'b0;
        gap        = 0;
        flush_ack  = 0;
        det_ready  = 1'b0;
        det_counts = '0;
        forever begin
            @(negedge clk);
            if (flush_ack != flush_req) begin
                flush_ack = flush_req;
                det_ready = 1'b0;
                pend      = 1'b0;
                gap       = 0;
                src_q.delete();
            end else if (pend) begin
                det_ready = 1'b0;
                pend      = 1'b0;
                gap       = $urandom_range(0, 3);
            end else if (det_re) begin
                re_cnt++;
                check("re_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("re_word", det_counts, exp_q.pop_front());
                end
                if (!(det_mode == M_STUCK && (re_cnt - re_base) == 2)) begin
                    pend = 1'b1;
                end
            end else if (!det_ready && det_mode != M_NEVER && src_q.size() > 0) begin
                if (gap == 0) begin
                    det_counts = src_q.pop_front();
                    det_ready  = 1'b1;
                end else begin
                    gap--;
                end
            end
        end
    end

    // One run from start to ack; called and returns at posedge+1.
    task automatic run(input int mode, input bit hold, input bit ack_with_start);
        int            en;
        int            cyc;
        logic [63:0]   e_sum;
        logic [CW-1:0] e_min;
        logic [CW-1:0] e_max;
        logic [SW-1:0] held_sum;
        en    = (mode == M_NEVER) ? 0 : ((mode == M_STUCK) ? 2 : N);
        e_sum = 0;
        e_min = '1;
        e_max = '0;
        exp_q.delete();
        for (int i = 0; i < en; i++) begin
            e_sum += 64'(words[i]);
            if (words[i] < e_min) e_min = words[i];
            if (words[i] > e_max) e_max = words[i];
            exp_q.push_back(words[i]);
        end
        det_mode = mode;
        re_base  = re_cnt;
        src_q    = words;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_run", busy, 1);
        cyc = 0;
        while (!res_valid && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_done", res_valid, 1);
        if (mode == M_NEVER) check("to_latency", cyc, TO);
        if (mode == M_NORMAL) check("min_latency", 64'(cyc >= 3 * N - 1), 64'd1);
        check("sum", res_sum, e_sum);
        check("min", res_min, e_min);
        check("max", res_max, e_max);
        check("mean", res_mean, e_sum >> L);
        check("n", res_n, en);
        check("timeout", res_timeout, 64'(mode != M_NORMAL));
        check("re_count", re_cnt - re_base, en);
        check("busy_done", busy, 1);
        if (hold) begin
            held_sum = res_sum;
            for (int i = 0; i < 20; i++) begin
                start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                check("hold_valid", res_valid, 1);
                check("hold_sum", res_sum, held_sum);
                check("hold_n", res_n, en);
            end
            start = 1'b0;
        end
        res_ack = 1'b1;
        start   = ack_with_start;
        @(posedge clk); #1;
        res_ack = 1'b0;
        start   = 1'b0;
        check("ack_valid", res_valid, 0);
        check("ack_busy", busy, 0);
        check("keep_sum", res_sum, e_sum);
        check("keep_min", res_min, e_min);
        @(posedge clk); #1;
        check("idle_stays", busy, 0);
        flush_req++;
        @(posedge clk); #1;
        det_mode = M_NORMAL;
    endtask

    task automatic fill_random(input int hi);
        words.delete();
        for (int i = 0; i < N; i++) words.push_back(CW'($urandom_range(0, hi)));
    endtask

    initial begin
        int cyc;
        reset   = 1'b0;
        start   = 1'b0;
        res_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_det_re", det_re, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_timeout", res_timeout, 0);
        check("rst_sum", res_sum, 0);
        check("rst_min", res_min, 16'hFFFF);
        check("rst_max", res_max, 0);
        check("rst_n", res_n, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // fixed example words
        words.delete();
        words.push_back(16'd100); words.push_back(16'd300);
        words.push_back(16'd200); words.push_back(16'd400);
        run(M_NORMAL, 1'b0, 1'b0);

        // largest words: sum must keep its carry bits
        words.delete();
        for (int i = 0; i < N; i++) words.push_back(16'hFFFF);
        run(M_NORMAL, 1'b0, 1'b0);

        // equal words
        words.delete();
        for (int i = 0; i < N; i++) words.push_back(16'd7);
        run(M_NORMAL, 1'b0, 1'b0);

        // detector never ready
        words.delete();
        run(M_NEVER, 1'b0, 1'b0);

        // ready stuck high after the second capture
        fill_random(65535);
        run(M_STUCK, 1'b0, 1'b0);

        // random runs, including a long hold and a start coinciding with ack
        for (int r = 0; r < 8; r++) begin
            fill_random((r % 2 == 0) ? 65535 : 3);
            run(M_NORMAL, r == 2, r == 3 || r == 2);
        end

        // reset asserted while the reader is in RELEASE
        fill_random(65535);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(words[i]);
        det_mode = M_NORMAL;
        re_base  = re_cnt;
        src_q    = words;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (dbg_state != 3'd3 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("saw_release", dbg_state, 3);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_det_re", det_re, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_sum", res_sum, 0);
        check("mid_rst_min", res_min, 16'hFFFF);
        check("mid_rst_max", res_max, 0);
        check("mid_rst_n", res_n, 0);
        check("mid_rst_state", dbg_state, 0);
        flush_req++;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_no_re", re_cnt - re_base, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", busy, 0);
        check("post_rst_valid", res_valid, 0);
        fill_random(65535);
        run(M_NORMAL, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
